// File: rtl/fw_uart_loader_if.sv
// Loader-side bus bundle: RX byte stream in, instruction-memory write port
// and boot-control status out. master = loader, slave = surrounding system.
interface fw_uart_loader_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        output cpu_hold,
        output load_done,
        output load_err,
        output err_code,
        output words_loaded
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        input  cpu_hold,
        input  load_done,
        input  load_err,
        input  err_code,
        input  words_loaded
    );
endinterface

// File: rtl/fw_uart_loader.sv
// Serial firmware loader: parses A5 / LEN_LO / LEN_HI / data / CSUM frames
// from the UART RX stream, writes little-endian words into instruction memory
// and holds the CPU in reset until a frame with a good checksum has landed.
module fw_uart_loader #(
    parameter int unsigned MEM_WORDS      = 16384,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic              clk,
    input logic              rst_n,
    fw_uart_loader_if.master bus
);
    localparam int unsigned      GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [16:0]      LEN_MAX  = 17'(MEM_WORDS);
    localparam logic [ADDR_W:0]  WORD_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    state_t            state_q;
    logic              rx_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_err_q;
    err_t              err_code_q;
    logic [ADDR_W:0]   words_q;
    logic [15:0]       len_q;
    logic [23:0]       word_q;
    logic [1:0]        lane_q;
    logic [7:0]        csum_q;
    logic [GAP_W-1:0]  gap_q;

    logic              accept_d;
    logic              active_d;
    logic [15:0]       len_d;
    logic              len_bad_d;
    logic              last_word_d;
    logic [31:0]       word_d;

    // Transfer qualification and frame-field decode from the current byte.
    always_comb begin
        accept_d    = bus.rx_valid & rx_ready_q;
        active_d    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
        len_d       = {bus.rx_data, len_q[7:0]};
        len_bad_d   = (len_d == '0) || ({1'b0, len_d} > LEN_MAX);
        last_word_d = (17'(words_q) + 17'd1) == {1'b0, len_q};
        word_d      = {bus.rx_data, word_q};
    end

    // Frame FSM with registered outputs; every transition except timeout
    // happens on an accepted byte. Timeout handling only acts when no byte
    // is accepted, so a byte on the expiry cycle always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            words_q     <= '0;
            len_q       <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
        end else begin
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;

            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (accept_d && (bus.rx_data == 8'hA5)) begin
                        state_q <= S_LEN0;
                        csum_q  <= '0;
                        words_q <= '0;
                        lane_q  <= '0;
                    end
                end

                S_LEN0: begin
                    if (accept_d) begin
                        len_q[7:0] <= bus.rx_data;
                        state_q    <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (accept_d) begin
                        len_q <= len_d;
                        if (len_bad_d) begin
                            state_q    <= S_ERR;
                            rx_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                            err_code_q <= ERR_LEN;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept_d) begin
                        csum_q <= csum_q ^ bus.rx_data;
                        lane_q <= lane_q + 2'd1;
                        case (lane_q)
                            2'd0: word_q[7:0]   <= bus.rx_data;
                            2'd1: word_q[15:8]  <= bus.rx_data;
                            2'd2: word_q[23:16] <= bus.rx_data;
                            default: begin
                                // Write strobe lands in the cycle after the
                                // 4th byte, overlapping the next acceptance.
                                mem_we_q    <= 1'b1;
                                mem_wstrb_q <= '1;
                                mem_addr_q  <= words_q[ADDR_W-1:0];
                                mem_wdata_q <= word_d;
                                words_q     <= words_q + WORD_ONE;
                                if (last_word_d) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end

                S_CSUM: begin
                    if (accept_d) begin
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == csum_q) begin
                            state_q     <= S_DONE;
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end
                end

                S_DONE: begin
                    rx_ready_q <= 1'b0;
                end

                S_ERR: begin
                    rx_ready_q <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (!active_d || accept_d) begin
                gap_q <= '0;
            end else if (gap_q == GAP_LAST) begin
                state_q    <= S_ERR;
                rx_ready_q <= 1'b0;
                load_err_q <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end else begin
                gap_q <= gap_q + GAP_ONE;
            end
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.err_code     = err_code_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_fw_uart_loader.sv
// Bench for fw_uart_loader with a small memory (16 words) and a 16-cycle
// inter-byte timeout so the boundaries are reachable quickly.
module tb_fw_uart_loader;
    localparam int MEM_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fw_uart_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    fw_uart_loader #(
        .MEM_WORDS(MEM_WORDS),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0]  fb[$];        // bytes of the current frame after the 0xA5
    bit          m_in_frame, m_term;
    int          m_len, m_gap;
    bit          m_ready, m_we, m_done, m_err;
    int          m_code, m_addr, m_words;
    logic [31:0] m_wdata;

    task automatic model_reset();
        fb.delete();
        m_in_frame = 0; m_term = 0; m_len = 0; m_gap = 0;
        m_ready = 0; m_we = 0; m_done = 0; m_err = 0;
        m_code = 0; m_addr = 0; m_words = 0; m_wdata = '0;
    endtask

    task automatic model_fail(input int code);
        m_term = 1; m_err = 1; m_code = code; m_ready = 0;
    endtask

    task automatic model_step(input bit acc, input logic [7:0] b);
        int n;
        logic [7:0] x;
        m_we = 0;
        if (m_term) return;
        if (!m_in_frame) begin
            if (acc && b == 8'hA5) begin
                m_in_frame = 1; fb.delete(); m_gap = 0; m_words = 0;
            end
        end else if (acc) begin
            m_gap = 0;
            fb.push_back(b);
            n = fb.size();
            if (n == 2) begin
                m_len = {fb[1], fb[0]};
                if (m_len == 0 || m_len > MEM_WORDS) model_fail(1);
            end else if (n >= 3 && n <= 2 + 4 * m_len) begin
                if ((n - 2) % 4 == 0) begin
                    m_we    = 1;
                    m_addr  = (n - 2) / 4 - 1;
                    m_wdata = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
                    m_words = m_addr + 1;
                end
            end else if (n == 3 + 4 * m_len) begin
                x = 8'h00;
                for (int i = 2; i <= n - 2; i++) x = x ^ fb[i];
                if (x == b) begin
                    m_term = 1; m_done = 1; m_ready = 0;
                end else begin
                    model_fail(2);
                end
            end
        end else begin
            m_gap++;
            if (m_gap >= TIMEOUT) model_fail(3);
        end
        if (!m_term) m_ready = 1;
    endtask

    // ---------------- per-cycle compare process ----------------
    bit          pend_rst_hi = 0;
    bit          pend_acc    = 0;
    logic [7:0]  pend_b      = '0;
    int          cyc = 0;
    int          we_count = 0;
    int          first_we_cyc = 0;
    int          last_we_cyc = 0;
    int          last_addr = 0;
    logic [31:0] mem_img [MEM_WORDS];

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_reset();
                we_count = 0;
                for (int i = 0; i < MEM_WORDS; i++) mem_img[i] = '0;
            end else if (pend_rst_hi) begin
                model_step(pend_acc, pend_b);
            end
            check("rx_ready", 32'(bus_if.rx_ready), 32'(m_ready));
            check("mem_we", 32'(bus_if.mem_we), 32'(m_we));
            check("cpu_hold", 32'(bus_if.cpu_hold), 32'(!m_done));
            check("load_done", 32'(bus_if.load_done), 32'(m_done));
            check("load_err", 32'(bus_if.load_err), 32'(m_err));
            check("err_code", 32'(bus_if.err_code), 32'(m_code));
            check("words_loaded", 32'(bus_if.words_loaded), 32'(m_words));
            if (!rst_n) begin
                check("rst_mem_addr", 32'(bus_if.mem_addr), 32'h0);
                check("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
                check("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'h0);
            end else if (m_we) begin
                check("mem_addr", 32'(bus_if.mem_addr), 32'(m_addr));
                check("mem_wdata", bus_if.mem_wdata, m_wdata);
                check("mem_wstrb", 32'(bus_if.mem_wstrb), 32'hF);
            end
            if (rst_n && bus_if.mem_we === 1'b1) begin
                if (we_count == 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                last_addr   = 32'(bus_if.mem_addr);
                mem_img[bus_if.mem_addr] = bus_if.mem_wdata;
                we_count++;
            end
            pend_rst_hi = rst_n;
            pend_acc    = bus_if.rx_valid & bus_if.rx_ready;
            pend_b      = bus_if.rx_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        bit  got = 0;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        while (!got && waited <= 40) begin
            @(negedge clk);
            if (bus_if.rx_ready === 1'b1) got = 1;
            @(posedge clk); #2;
            waited++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_bound: byte 0x%0h not accepted within 40 cycles at %0t", b, $time);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        bus_if.rx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    logic [7:0] fr[$];
    logic [7:0] x;

    initial begin
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_rx_ready", 32'(bus_if.rx_ready), 32'h0);
        check("reset_cpu_hold", 32'(bus_if.cpu_hold), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("ready_after_release", 32'(bus_if.rx_ready), 32'h1);

        // 1: two-word frame, good checksum
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C});
        @(negedge clk);
        check("t1_done", 32'(bus_if.load_done), 32'h1);
        check("t1_hold", 32'(bus_if.cpu_hold), 32'h0);
        check("t1_words", 32'(bus_if.words_loaded), 32'h2);
        check("t1_mem0", mem_img[0], 32'h0000_0013);
        check("t1_mem1", mem_img[1], 32'h0000_006F);
        check("t1_we_count", 32'(we_count), 32'h2);

        // 2: bad checksum, words still written
        do_reset();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h6F, 8'h00, 8'h00, 8'h00, 8'h00});
        @(negedge clk);
        check("t2_err", 32'(bus_if.load_err), 32'h1);
        check("t2_code", 32'(bus_if.err_code), 32'h2);
        check("t2_hold", 32'(bus_if.cpu_hold), 32'h1);
        check("t2_mem0", mem_img[0], 32'h0000_0013);
        check("t2_mem1", mem_img[1], 32'h0000_006F);

        // 3: zero and oversize lengths
        do_reset();
        send_frame('{8'hA5, 8'h00, 8'h00});
        @(negedge clk);
        check("t3a_code", 32'(bus_if.err_code), 32'h1);
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h40});
        repeat (4) @(negedge clk);
        check("t3b_code", 32'(bus_if.err_code), 32'h1);
        check("t3b_no_we", 32'(we_count), 32'h0);

        // 4: timeout exactly at the 16th idle cycle, and a byte on that cycle
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hAA});
        repeat (15) @(posedge clk);
        #2;
        check("t4_err_at_15", 32'(bus_if.load_err), 32'h0);
        @(posedge clk); #2;
        check("t4_err_at_16", 32'(bus_if.load_err), 32'h1);
        check("t4_code", 32'(bus_if.err_code), 32'h3);
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hAA});
        repeat (15) @(posedge clk);
        #2;
        send_frame('{8'h00, 8'h00, 8'h00, 8'hAA});
        @(negedge clk);
        check("t4b_err", 32'(bus_if.load_err), 32'h0);
        check("t4b_done", 32'(bus_if.load_done), 32'h1);

        // 5: leading garbage, then reset in the middle of a frame
        do_reset();
        send_frame('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00,
                     8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C});
        @(negedge clk);
        check("t5_done", 32'(bus_if.load_done), 32'h1);
        check("t5_words", 32'(bus_if.words_loaded), 32'h2);
        check("t5_mem1", mem_img[1], 32'h0000_006F);
        do_reset();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F});
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(bus_if.rx_ready), 32'h0);
        check("t5_rst_words", 32'(bus_if.words_loaded), 32'h0);
        check("t5_rst_hold", 32'(bus_if.cpu_hold), 32'h1);
        check("t5_rst_we", 32'(bus_if.mem_we), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C});
        @(negedge clk);
        check("t5b_done", 32'(bus_if.load_done), 32'h1);

        // 6: full-depth frame, back-to-back bytes
        do_reset();
        fr = '{8'hA5, 8'h10, 8'h00};
        x  = 8'h00;
        for (int i = 0; i < 4 * MEM_WORDS; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            fr.push_back(r);
            x = x ^ r;
        end
        fr.push_back(x);
        send_frame(fr);
        @(negedge clk);
        check("t6_we_count", 32'(we_count), 32'd16);
        check("t6_last_addr", 32'(last_addr), 32'd15);
        check("t6_words", 32'(bus_if.words_loaded), 32'd16);
        check("t6_done", 32'(bus_if.load_done), 32'h1);
        check("t6_we_spacing", 32'(last_we_cyc - first_we_cyc), 32'd60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
